// File: rtl/rv_mc_control_unit.sv
// Multicycle RV64I control FSM: sequences fetch/decode/execute/memory/writeback strobes,
// with a mem_ready handshake and timeout, branch resolution, and illegal/fault traps.
module rv_mc_control_unit #(
    parameter int unsigned MEM_TIMEOUT  = 16,
    parameter bit          TRAP_ILLEGAL = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        alu_zero,
    input  logic        alu_lt,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic [1:0]  mem_size,
    output logic        mem_unsigned,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        ir_load,
    output logic        rega_load,
    output logic        regb_load,
    output logic        aluout_load,
    output logic        mdr_load,
    output logic [2:0]  alu_op,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  wb_sel,
    output logic        reg_write,
    output logic        exc_illegal,
    output logic        exc_fault
);
    localparam int unsigned CW = $clog2(MEM_TIMEOUT + 1);

    localparam logic [2:0] ALU_ADD = 3'd1;
    localparam logic [2:0] ALU_SUB = 3'd2;
    localparam logic [2:0] ALU_AND = 3'd3;
    localparam logic [2:0] ALU_SLT = 3'd4;

    typedef enum logic [4:0] {
        RESET, FETCH_REQ, DECODE, EXEC_R, EXEC_I, WB_ALU, ADDR_LD, ADDR_ST,
        MEM_RD, MEM_WR, WB_LD, BRANCH, LUI, JAL, JALR, FAULT, ILLEGAL
    } state_t;

    state_t          state, state_next, dec_state;
    logic [CW-1:0]   wait_cnt;
    logic [6:0]      opcode, funct7;
    logic [2:0]      funct3;
    logic            in_access, mem_timeout, br_taken;

    assign opcode      = instr[6:0];
    assign funct3      = instr[14:12];
    assign funct7      = instr[31:25];
    assign in_access   = (state == FETCH_REQ) || (state == MEM_RD) || (state == MEM_WR);
    // The MEM_TIMEOUT-th consecutive idle cycle faults; a ready in any cycle completes.
    assign mem_timeout = !mem_ready && (wait_cnt == CW'(MEM_TIMEOUT - 1));

    // Reset parks in RESET for one cycle so every strobe reads 0 right after rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RESET;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= (in_access && !mem_ready) ? wait_cnt + CW'(1) : '0;
        end
    end

    always_comb begin
        dec_state = TRAP_ILLEGAL ? ILLEGAL : FETCH_REQ;
        case (opcode)
            7'b0110011: if ((funct7 == 7'b0000000 && (funct3 == 3'b000 || funct3 == 3'b111 ||
                             funct3 == 3'b010)) || (funct7 == 7'b0100000 && funct3 == 3'b000))
                            dec_state = EXEC_R;
            7'b0010011: if (funct3 == 3'b000 || funct3 == 3'b010) dec_state = EXEC_I;
            7'b0000011: if (funct3 != 3'b111) dec_state = ADDR_LD;
            7'b0100011: if (!funct3[2]) dec_state = ADDR_ST;
            7'b1100011: if (funct3[1] == 1'b0) dec_state = BRANCH;
            7'b0110111: dec_state = LUI;
            7'b1101111: dec_state = JAL;
            7'b1100111: if (funct3 == 3'b000) dec_state = JALR;
            default: ;
        endcase
        if (instr == '0) dec_state = FETCH_REQ;
    end

    always_comb begin
        case (funct3)
            3'b000:  br_taken = alu_zero;
            3'b001:  br_taken = !alu_zero;
            3'b100:  br_taken = alu_lt;
            3'b101:  br_taken = !alu_lt;
            default: br_taken = 1'b0;
        endcase
    end

    always_comb begin
        state_next   = state;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        mem_size     = 2'd0;
        mem_unsigned = 1'b0;
        pc_write     = 1'b0;
        pc_src       = 2'd0;
        ir_load      = 1'b0;
        rega_load    = 1'b0;
        regb_load    = 1'b0;
        aluout_load  = 1'b0;
        mdr_load     = 1'b0;
        alu_op       = 3'd0;
        alu_src_a    = 1'b0;
        alu_src_b    = 2'd0;
        wb_sel       = 2'd0;
        reg_write    = 1'b0;
        exc_illegal  = 1'b0;
        exc_fault    = 1'b0;
        case (state)
            RESET: state_next = FETCH_REQ;
            FETCH_REQ: begin
                mem_req   = 1'b1;
                mem_size  = 2'd2;
                alu_src_b = 2'd1;
                alu_op    = ALU_ADD;
                if (mem_ready) begin
                    ir_load    = 1'b1;
                    pc_write   = 1'b1;
                    state_next = DECODE;
                end else if (mem_timeout) begin
                    state_next = FAULT;
                end
            end
            DECODE: begin
                rega_load   = 1'b1;
                regb_load   = 1'b1;
                aluout_load = 1'b1;
                alu_src_b   = 2'd3;
                alu_op      = ALU_ADD;
                state_next  = dec_state;
            end
            EXEC_R, EXEC_I: begin
                alu_src_a   = 1'b1;
                aluout_load = 1'b1;
                if (state == EXEC_R) begin
                    alu_src_b = 2'd0;
                    if (funct3 == 3'b111)      alu_op = ALU_AND;
                    else if (funct3 == 3'b010) alu_op = ALU_SLT;
                    else                       alu_op = funct7[5] ? ALU_SUB : ALU_ADD;
                end else begin
                    alu_src_b = 2'd2;
                    alu_op    = (funct3 == 3'b010) ? ALU_SLT : ALU_ADD;
                end
                state_next = WB_ALU;
            end
            WB_ALU: begin
                reg_write  = 1'b1;
                state_next = FETCH_REQ;
            end
            ADDR_LD, ADDR_ST: begin
                alu_src_a   = 1'b1;
                alu_src_b   = 2'd2;
                alu_op      = ALU_ADD;
                aluout_load = 1'b1;
                state_next  = (state == ADDR_LD) ? MEM_RD : MEM_WR;
            end
            MEM_RD, MEM_WR: begin
                mem_req      = 1'b1;
                mem_we       = (state == MEM_WR);
                mem_addr_sel = 1'b1;
                mem_size     = funct3[1:0];
                mem_unsigned = funct3[2];
                if (mem_ready) begin
                    mdr_load   = (state == MEM_RD);
                    state_next = (state == MEM_RD) ? WB_LD : FETCH_REQ;
                end else if (mem_timeout) begin
                    state_next = FAULT;
                end
            end
            WB_LD: begin
                wb_sel     = 2'd1;
                reg_write  = 1'b1;
                state_next = FETCH_REQ;
            end
            BRANCH: begin
                alu_src_a  = 1'b1;
                alu_op     = ALU_SUB;
                pc_write   = br_taken;
                pc_src     = 2'd1;
                state_next = FETCH_REQ;
            end
            LUI: begin
                wb_sel     = 2'd2;
                reg_write  = 1'b1;
                state_next = FETCH_REQ;
            end
            JAL: begin
                wb_sel     = 2'd3;
                reg_write  = 1'b1;
                pc_write   = 1'b1;
                pc_src     = 2'd1;
                state_next = FETCH_REQ;
            end
            JALR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'd2;
                alu_op     = ALU_ADD;
                wb_sel     = 2'd3;
                reg_write  = 1'b1;
                pc_write   = 1'b1;
                pc_src     = 2'd2;
                state_next = FETCH_REQ;
            end
            FAULT:   exc_fault   = 1'b1;
            ILLEGAL: exc_illegal = 1'b1;
            default: state_next = RESET;
        endcase
    end
endmodule

// File: tb/tb_rv_mc_control_unit.sv
// Directed bench for rv_mc_control_unit: a trapping instance (MEM_TIMEOUT=4) and a
// non-trapping instance (TRAP_ILLEGAL=0) share the same stimulus.
module tb_rv_mc_control_unit;
    logic        clk = 1'b0;
    logic        rst, alu_zero, alu_lt, mem_ready;
    logic [31:0] instr;

    logic        mem_req, mem_we, mem_addr_sel, mem_unsigned, pc_write, ir_load;
    logic        rega_load, regb_load, aluout_load, mdr_load, alu_src_a, reg_write;
    logic        exc_illegal, exc_fault;
    logic [1:0]  mem_size, pc_src, alu_src_b, wb_sel;
    logic [2:0]  alu_op;

    logic        n_mem_req, n_mem_we, n_mem_addr_sel, n_mem_unsigned, n_pc_write, n_ir_load;
    logic        n_rega_load, n_regb_load, n_aluout_load, n_mdr_load, n_alu_src_a, n_reg_write;
    logic        n_exc_illegal, n_exc_fault;
    logic [1:0]  n_mem_size, n_pc_src, n_alu_src_b, n_wb_sel;
    logic [2:0]  n_alu_op;

    logic [24:0] outs, n_outs;
    int          checks = 0;
    int          errors = 0;

    assign outs = {mem_req, mem_we, mem_addr_sel, mem_size, mem_unsigned, pc_write, pc_src,
                   ir_load, rega_load, regb_load, aluout_load, mdr_load, alu_op, alu_src_a,
                   alu_src_b, wb_sel, reg_write, exc_illegal, exc_fault};
    assign n_outs = {n_mem_req, n_mem_we, n_mem_addr_sel, n_mem_size, n_mem_unsigned, n_pc_write,
                     n_pc_src, n_ir_load, n_rega_load, n_regb_load, n_aluout_load, n_mdr_load,
                     n_alu_op, n_alu_src_a, n_alu_src_b, n_wb_sel, n_reg_write, n_exc_illegal,
                     n_exc_fault};

    always #5 clk = ~clk;

    rv_mc_control_unit #(.MEM_TIMEOUT(4), .TRAP_ILLEGAL(1'b1)) dut (
        .clk(clk), .rst(rst), .instr(instr), .alu_zero(alu_zero), .alu_lt(alu_lt),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
        .mem_size(mem_size), .mem_unsigned(mem_unsigned), .pc_write(pc_write), .pc_src(pc_src),
        .ir_load(ir_load), .rega_load(rega_load), .regb_load(regb_load),
        .aluout_load(aluout_load), .mdr_load(mdr_load), .alu_op(alu_op), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .wb_sel(wb_sel), .reg_write(reg_write),
        .exc_illegal(exc_illegal), .exc_fault(exc_fault)
    );

    rv_mc_control_unit #(.MEM_TIMEOUT(16), .TRAP_ILLEGAL(1'b0)) dut_nt (
        .clk(clk), .rst(rst), .instr(instr), .alu_zero(alu_zero), .alu_lt(alu_lt),
        .mem_ready(mem_ready), .mem_req(n_mem_req), .mem_we(n_mem_we),
        .mem_addr_sel(n_mem_addr_sel), .mem_size(n_mem_size), .mem_unsigned(n_mem_unsigned),
        .pc_write(n_pc_write), .pc_src(n_pc_src), .ir_load(n_ir_load),
        .rega_load(n_rega_load), .regb_load(n_regb_load), .aluout_load(n_aluout_load),
        .mdr_load(n_mdr_load), .alu_op(n_alu_op), .alu_src_a(n_alu_src_a),
        .alu_src_b(n_alu_src_b), .wb_sel(n_wb_sel), .reg_write(n_reg_write),
        .exc_illegal(n_exc_illegal), .exc_fault(n_exc_fault)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Entered at posedge+1 in FETCH_REQ; leaves at posedge+1 in DECODE.
    task automatic fetch(input logic [31:0] ins);
        instr     = ins;
        mem_ready = 1'b1;
        @(negedge clk);
        check("fetch_req", mem_req, 1);
        check("fetch_irpc", {ir_load, pc_write}, 2'b11);
        cyc();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; instr = '0; alu_zero = 1'b0; alu_lt = 1'b0; mem_ready = 1'b0;
        cyc(); cyc();
        @(negedge clk);
        check("rst_outs", outs, 0);
        check("rst_outs_nt", n_outs, 0);
        rst = 1'b0;
        cyc();

        // add x3,x1,x2: FETCH, DECODE, EXEC_R, WB_ALU
        fetch(32'h002081B3);
        @(negedge clk);
        check("dec_srcb", alu_src_b, 3);
        check("dec_nowrite", {reg_write, pc_write, mem_we}, 0);
        cyc();
        @(negedge clk);
        check("add_op", alu_op, 1);
        check("add_exec", {alu_src_a, aluout_load, reg_write}, 3'b110);
        cyc();
        @(negedge clk);
        check("add_wb", {reg_write, wb_sel}, 3'b100);
        cyc();

        // sub x3,x1,x2
        fetch(32'h402081B3);
        cyc();
        @(negedge clk);
        check("sub_op", alu_op, 2);
        cyc(); cyc();

        // ld x5,8(x1) with three idle cycles before ready
        fetch(32'h0080B283);
        cyc();
        @(negedge clk);
        check("ld_addr", {alu_src_b, alu_op}, {2'd2, 3'd1});
        cyc();
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("ld_wait_req", {mem_req, mem_size, mdr_load}, {1'b1, 2'd3, 1'b0});
            cyc();
        end
        mem_ready = 1'b1;
        @(negedge clk);
        check("ld_done", {mem_req, mem_addr_sel, mem_unsigned, mdr_load}, 4'b1101);
        cyc();
        @(negedge clk);
        check("ld_wb", {reg_write, wb_sel}, 3'b101);
        cyc();

        // beq taken / not taken, bge taken on !lt, blt not taken on !lt
        fetch(32'h00208063);
        cyc();
        alu_zero = 1'b1;
        @(negedge clk);
        check("beq_t", {pc_write, pc_src, alu_op}, {1'b1, 2'd1, 3'd2});
        cyc();
        alu_zero = 1'b0;
        fetch(32'h00208063);
        cyc();
        @(negedge clk);
        check("beq_nt", pc_write, 0);
        cyc();
        fetch(32'h0020D063);
        cyc();
        @(negedge clk);
        check("bge_t", pc_write, 1);
        cyc();
        fetch(32'h0020C063);
        cyc();
        @(negedge clk);
        check("blt_nt", pc_write, 0);
        cyc();

        // lui x5,0 and jalr x1,0(x5)
        fetch(32'h000002B7);
        cyc();
        @(negedge clk);
        check("lui_wb", {reg_write, wb_sel, pc_write}, 4'b1100);
        cyc();
        fetch(32'h000280E7);
        cyc();
        @(negedge clk);
        check("jalr", {reg_write, wb_sel, pc_write, pc_src}, 6'b111110);
        cyc();

        // instr==0 decodes as NOP; then sd x2,16(x1) interrupted by rst mid-wait
        fetch(32'h00000000);
        cyc();
        fetch(32'h0020B823);
        cyc(); cyc();
        mem_ready = 1'b0;
        @(negedge clk);
        check("sd_wait", {mem_req, mem_we, mem_size}, 4'b1111);
        cyc();
        rst = 1'b1;
        @(negedge clk);
        check("sd_wait2", mem_we, 1);
        cyc();
        @(negedge clk);
        check("sd_rst_outs", outs, 0);
        rst = 1'b0;
        cyc();

        // fetch never completes: fault after the 4th idle cycle
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("to_wait", {mem_req, mem_we, ir_load}, 3'b100);
            cyc();
        end
        @(negedge clk);
        check("fault_set", {exc_fault, mem_req, pc_write, reg_write}, 4'b1000);
        cyc();
        @(negedge clk);
        check("fault_held", outs, 25'd1);
        rst = 1'b1;
        cyc();
        @(negedge clk);
        check("fault_clr", exc_fault, 0);
        rst = 1'b0;
        cyc();

        // undecodable instruction: trap vs. NOP instance
        fetch(32'hFFFF_FFFF);
        @(negedge clk);
        check("ill_dec_nowrite", {reg_write, pc_write, mem_we}, 0);
        cyc();
        @(negedge clk);
        check("ill_trap", {exc_illegal, mem_req}, 2'b10);
        check("ill_nop_nt", {n_exc_illegal, n_mem_req}, 2'b01);
        cyc();
        @(negedge clk);
        check("ill_held", exc_illegal, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
